// File: rtl/nanorv32_ahb_master_bridge.sv
// nanorv32_ahb_master_bridge
// Converts single CPU load/store requests into AHB-Lite SINGLE transfers.
//
// Ports
//   clk_in, rst      : clock, synchronous active-high reset
//   cpu_addr         : request byte address
//   cpu_bytesel      : byte lanes, 4'b0000 = read, legal write patterns below
//   cpu_din          : lane-aligned write data
//   cpu_en           : request strobe, only looked at in IDLE
//   cpu_dout         : read data, valid while cpu_ready is high
//   cpu_ready        : one-cycle completion pulse
//   cpu_err          : one-cycle error-completion pulse
//   cpu_busy         : high whenever the bridge is not idle
//   haddr .. hwdata  : AHB-Lite master outputs
//   hrdata, hready,
//   hresp            : AHB-Lite master inputs
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for cpu_en; illegal byte lanes go straight to DONE
// ADDR  | NONSEQ address phase, held until hready
// DATA  | data phase, waiting for hready / first cycle of an error
// ERR   | second cycle of the two-cycle error response
// DONE  | single completion cycle, cpu_ready or cpu_err pulses here
module nanorv32_ahb_master_bridge (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_bytesel,
    input  logic [31:0] cpu_din,
    input  logic        cpu_en,
    output logic [31:0] cpu_dout,
    output logic        cpu_ready,
    output logic        cpu_err,
    output logic        cpu_busy,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic [1:0]  htrans,
    output logic        hmastlock,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t      state, state_nxt;
    logic [31:0] haddr_nxt;
    logic        hwrite_nxt;
    logic [2:0]  hsize_nxt;
    logic [1:0]  htrans_nxt;
    logic [31:0] hwdata_nxt;
    logic [31:0] cpu_dout_nxt;
    logic        cpu_ready_nxt;
    logic        cpu_err_nxt;
    logic        cpu_busy_nxt;

    logic        req_legal;
    logic [2:0]  req_size;
    logic [1:0]  req_lo;

    // Only SINGLE, non-locked, privileged data accesses are ever issued.
    assign hburst    = 3'b000;
    assign hprot     = 4'b0011;
    assign hmastlock = 1'b0;

    // Byte-lane pattern to transfer size and low address bits. Reads are
    // always issued as full words; the CPU picks its lanes out of cpu_dout.
    always_comb begin
        req_legal = 1'b1;
        req_size  = 3'b010;
        req_lo    = 2'b00;
        case (cpu_bytesel)
            4'b0000, 4'b1111: begin
                req_size = 3'b010;
            end
            4'b0011: req_size = 3'b001;
            4'b1100: begin
                req_size = 3'b001;
                req_lo   = 2'b10;
            end
            4'b0001: req_size = 3'b000;
            4'b0010: begin
                req_size = 3'b000;
                req_lo   = 2'b01;
            end
            4'b0100: begin
                req_size = 3'b000;
                req_lo   = 2'b10;
            end
            4'b1000: begin
                req_size = 3'b000;
                req_lo   = 2'b11;
            end
            default: req_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        haddr_nxt     = haddr;
        hwrite_nxt    = hwrite;
        hsize_nxt     = hsize;
        htrans_nxt    = htrans;
        hwdata_nxt    = hwdata;
        cpu_dout_nxt  = cpu_dout;
        cpu_ready_nxt = 1'b0;
        cpu_err_nxt   = 1'b0;

        case (state)
            ST_IDLE: begin
                htrans_nxt = HTRANS_IDLE;
                if (cpu_en) begin
                    if (req_legal) begin
                        haddr_nxt  = (cpu_addr & 32'hFFFF_FFFC) | {30'd0, req_lo};
                        hsize_nxt  = req_size;
                        hwrite_nxt = (cpu_bytesel != 4'b0000);
                        hwdata_nxt = cpu_din;
                        htrans_nxt = HTRANS_NONSEQ;
                        state_nxt  = ST_ADDR;
                    end else begin
                        cpu_err_nxt = 1'b1;
                        state_nxt   = ST_DONE;
                    end
                end
            end
            ST_ADDR: begin
                if (hready) begin
                    htrans_nxt = HTRANS_IDLE;
                    state_nxt  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (hready) begin
                    state_nxt = ST_DONE;
                    // hready with hresp already high means the first error
                    // cycle was missed; still report it as an error.
                    if (hresp) begin
                        cpu_err_nxt = 1'b1;
                    end else begin
                        cpu_ready_nxt = 1'b1;
                        if (!hwrite) begin
                            cpu_dout_nxt = hrdata;
                        end
                    end
                end else if (hresp) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_ERR: begin
                if (hready) begin
                    cpu_err_nxt = 1'b1;
                    state_nxt   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                htrans_nxt = HTRANS_IDLE;
                state_nxt  = ST_IDLE;
            end
        endcase

        cpu_busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= ST_IDLE;
            haddr     <= 32'd0;
            hwrite    <= 1'b0;
            hsize     <= 3'b010;
            htrans    <= HTRANS_IDLE;
            hwdata    <= 32'd0;
            cpu_dout  <= 32'd0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_busy  <= 1'b0;
        end else begin
            state     <= state_nxt;
            haddr     <= haddr_nxt;
            hwrite    <= hwrite_nxt;
            hsize     <= hsize_nxt;
            htrans    <= htrans_nxt;
            hwdata    <= hwdata_nxt;
            cpu_dout  <= cpu_dout_nxt;
            cpu_ready <= cpu_ready_nxt;
            cpu_err   <= cpu_err_nxt;
            cpu_busy  <= cpu_busy_nxt;
        end
    end

endmodule

// File: tb/tb_nanorv32_ahb_master_bridge.sv
// Testbench for nanorv32_ahb_master_bridge: directed vector table, a reset
// abort sequence, then random transactions checked against a transaction
// level model (expected address/size, latency and read data).
module tb_nanorv32_ahb_master_bridge;

    logic        clk_in = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_bytesel;
    logic [31:0] cpu_din;
    logic        cpu_en;
    logic [31:0] cpu_dout;
    logic        cpu_ready;
    logic        cpu_err;
    logic        cpu_busy;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_in = ~clk_in;

    nanorv32_ahb_master_bridge dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .cpu_addr    (cpu_addr),
        .cpu_bytesel (cpu_bytesel),
        .cpu_din     (cpu_din),
        .cpu_en      (cpu_en),
        .cpu_dout    (cpu_dout),
        .cpu_ready   (cpu_ready),
        .cpu_err     (cpu_err),
        .cpu_busy    (cpu_busy),
        .haddr       (haddr),
        .hwrite      (hwrite),
        .hsize       (hsize),
        .hburst      (hburst),
        .hprot       (hprot),
        .htrans      (htrans),
        .hmastlock   (hmastlock),
        .hwdata      (hwdata),
        .hrdata      (hrdata),
        .hready      (hready),
        .hresp       (hresp)
    );

    // One request plus slave behaviour and the expected outcome.
    // aw = address-phase wait cycles, dw = data-phase wait cycles,
    // er = slave answers with a two-cycle ERROR, e_lat = cycles from the
    // cpu_en cycle to the completion pulse (1 means illegal lanes).
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  bs;
        logic [31:0] din;
        int          aw;
        int          dw;
        bit          er;
        logic [31:0] rd;
        bit          hold;
        logic [31:0] e_haddr;
        logic [2:0]  e_hsize;
        bit          e_hwrite;
        int          e_lat;
        bit          e_err;
        logic [31:0] e_dout;
    } vec_t;

    vec_t vecs[13];
    logic [31:0] model_dout;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Transaction-level decode of the byte lanes.
    function automatic bit lanes_legal(input logic [3:0] bs, output logic [2:0] sz,
                                       output logic [1:0] lo);
        int ones;
        ones = $countones(bs);
        sz   = 3'b010;
        lo   = 2'b00;
        if (bs == 4'b0000 || bs == 4'b1111) return 1'b1;
        if (ones == 1) begin
            sz = 3'b000;
            for (int i = 0; i < 4; i++) if (bs[i]) lo = 2'(i);
            return 1'b1;
        end
        if (bs == 4'b0011) begin
            sz = 3'b001;
            return 1'b1;
        end
        if (bs == 4'b1100) begin
            sz = 3'b001;
            lo = 2'b10;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Entered #1 after a rising edge with the DUT idle; leaves it the same way.
    task automatic run_txn(input vec_t v, input string nm);
        int   total;
        bit   legal;
        int   exp_ns;
        int   ns_cnt;
        int   first_ns;
        int   rdy_cnt;
        int   rdy_cyc;
        int   err_cnt;
        int   err_cyc;
        bit   addr_bad;
        bit   busy_bad;
        bit   trans_bad;
        bit   both;
        bit   exp_busy;
        int   dk;
        logic [31:0] dout_at;
        logic [31:0] hw_seen;

        total    = v.e_lat;
        legal    = (v.e_lat > 1);
        exp_ns   = legal ? v.aw + 1 : 0;
        ns_cnt   = 0;
        first_ns = -1;
        rdy_cnt  = 0;
        rdy_cyc  = -1;
        err_cnt  = 0;
        err_cyc  = -1;
        addr_bad = 1'b0;
        busy_bad = 1'b0;
        trans_bad = 1'b0;
        both     = 1'b0;
        dout_at  = 32'hX;
        hw_seen  = 32'hX;

        for (int k = 0; k <= total + 2; k++) begin
            cpu_en = (k == 0) || (v.hold && k <= total);
            if (k == 0) begin
                cpu_addr    = v.addr;
                cpu_bytesel = v.bs;
                cpu_din     = v.din;
            end
            hrdata = $urandom;
            hready = 1'b1;
            hresp  = 1'b0;
            if (legal && k >= 1 && k <= v.aw + 1) begin
                hready = (k == v.aw + 1);
            end
            dk = k - (v.aw + 2);
            if (legal && dk >= 0) begin
                if (dk < v.dw) begin
                    hready = 1'b0;
                end else if (dk == v.dw) begin
                    if (v.er) begin
                        hready = 1'b0;
                        hresp  = 1'b1;
                    end else begin
                        hrdata = v.rd;
                    end
                end else if (v.er && dk == v.dw + 1) begin
                    hresp = 1'b1;
                end
            end

            @(negedge clk_in);
            if (htrans == 2'b10) begin
                ns_cnt++;
                if (first_ns < 0) first_ns = k;
                if (haddr !== v.e_haddr || hsize !== v.e_hsize || hwrite !== v.e_hwrite)
                    addr_bad = 1'b1;
            end
            if (htrans == 2'b01 || htrans == 2'b11) trans_bad = 1'b1;
            exp_busy = (k >= 1 && k <= total);
            if (cpu_busy !== exp_busy) busy_bad = 1'b1;
            if (cpu_ready && cpu_err) both = 1'b1;
            if (cpu_ready) begin
                rdy_cnt++;
                rdy_cyc = k;
                dout_at = cpu_dout;
            end
            if (cpu_err) begin
                err_cnt++;
                err_cyc = k;
            end
            if (legal && k == v.aw + 2) hw_seen = hwdata;
            @(posedge clk_in);
            #1;
        end
        cpu_en = 1'b0;

        chk({nm, " nonseq count"}, 32'(ns_cnt), 32'(exp_ns));
        if (legal) begin
            chk({nm, " nonseq start cycle"}, 32'(first_ns), 32'd1);
            chk({nm, " address phase outputs bad"}, 32'(addr_bad), 32'd0);
            chk({nm, " hwdata in data phase"}, hw_seen, v.din);
        end
        chk({nm, " htrans BUSY/SEQ seen"}, 32'(trans_bad), 32'd0);
        chk({nm, " cpu_busy profile bad"}, 32'(busy_bad), 32'd0);
        chk({nm, " ready and err together"}, 32'(both), 32'd0);
        chk({nm, " cpu_ready pulses"}, 32'(rdy_cnt), v.e_err ? 32'd0 : 32'd1);
        chk({nm, " cpu_err pulses"}, 32'(err_cnt), v.e_err ? 32'd1 : 32'd0);
        if (v.e_err) begin
            chk({nm, " cpu_err cycle"}, 32'(err_cyc), 32'(total));
        end else begin
            chk({nm, " cpu_ready cycle"}, 32'(rdy_cyc), 32'(total));
            chk({nm, " cpu_dout at ready"}, dout_at, v.e_dout);
        end
        chk({nm, " cpu_dout after"}, cpu_dout, v.e_dout);
    endtask

    initial begin
        vec_t        rv;
        logic [2:0]  sz;
        logic [1:0]  lo;
        bit          lg;
        int          pulses;

        vecs[0]  = '{32'h4000_0008, 4'b1111, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0,         1'b0,
                     32'h4000_0008, 3'b010, 1'b1, 3, 1'b0, 32'h0000_0000};
        vecs[1]  = '{32'h4000_0003, 4'b0000, 32'h0,         0, 2, 1'b0, 32'h1122_3344, 1'b0,
                     32'h4000_0000, 3'b010, 1'b0, 5, 1'b0, 32'h1122_3344};
        vecs[2]  = '{32'h0000_0100, 4'b1100, 32'hAABB_0000, 0, 0, 1'b0, 32'h0,         1'b0,
                     32'h0000_0102, 3'b001, 1'b1, 3, 1'b0, 32'h1122_3344};
        vecs[3]  = '{32'h0000_0040, 4'b0101, 32'h1234_5678, 0, 0, 1'b0, 32'h0,         1'b0,
                     32'h0000_0000, 3'b010, 1'b1, 1, 1'b1, 32'h1122_3344};
        vecs[4]  = '{32'h0000_0200, 4'b0000, 32'h0,         0, 0, 1'b1, 32'hBAD0_BAD0, 1'b0,
                     32'h0000_0200, 3'b010, 1'b0, 4, 1'b1, 32'h1122_3344};
        vecs[5]  = '{32'h0000_0013, 4'b0001, 32'h0000_00A5, 0, 0, 1'b0, 32'h0,         1'b0,
                     32'h0000_0010, 3'b000, 1'b1, 3, 1'b0, 32'h1122_3344};
        vecs[6]  = '{32'h0000_0020, 4'b0010, 32'h0000_5A00, 0, 0, 1'b0, 32'h0,         1'b0,
                     32'h0000_0021, 3'b000, 1'b1, 3, 1'b0, 32'h1122_3344};
        vecs[7]  = '{32'h0000_0034, 4'b0100, 32'h00C3_0000, 0, 0, 1'b0, 32'h0,         1'b0,
                     32'h0000_0036, 3'b000, 1'b1, 3, 1'b0, 32'h1122_3344};
        vecs[8]  = '{32'h0000_0048, 4'b1000, 32'h3C00_0000, 0, 0, 1'b0, 32'h0,         1'b0,
                     32'h0000_004B, 3'b000, 1'b1, 3, 1'b0, 32'h1122_3344};
        vecs[9]  = '{32'h0000_0033, 4'b0011, 32'h0000_BEEF, 0, 0, 1'b0, 32'h0,         1'b0,
                     32'h0000_0030, 3'b001, 1'b1, 3, 1'b0, 32'h1122_3344};
        vecs[10] = '{32'h0000_0080, 4'b0000, 32'h0,         2, 1, 1'b0, 32'hCAFE_F00D, 1'b0,
                     32'h0000_0080, 3'b010, 1'b0, 6, 1'b0, 32'hCAFE_F00D};
        vecs[11] = '{32'h0000_0044, 4'b1111, 32'h0BAD_F00D, 0, 1, 1'b0, 32'h0,         1'b1,
                     32'h0000_0044, 3'b010, 1'b1, 4, 1'b0, 32'hCAFE_F00D};
        vecs[12] = '{32'h0000_0300, 4'b1111, 32'h7777_7777, 0, 2, 1'b1, 32'h0,         1'b0,
                     32'h0000_0300, 3'b010, 1'b1, 6, 1'b1, 32'hCAFE_F00D};

        rst         = 1'b1;
        cpu_en      = 1'b0;
        cpu_addr    = 32'h0;
        cpu_bytesel = 4'b0000;
        cpu_din     = 32'h0;
        hrdata      = 32'h0;
        hready      = 1'b1;
        hresp       = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("reset htrans", 32'(htrans), 32'd0);
        chk("reset haddr", haddr, 32'd0);
        chk("reset hwrite", 32'(hwrite), 32'd0);
        chk("reset hsize", 32'(hsize), 32'd2);
        chk("reset hwdata", hwdata, 32'd0);
        chk("reset cpu_dout", cpu_dout, 32'd0);
        chk("reset cpu_ready", 32'(cpu_ready), 32'd0);
        chk("reset cpu_err", 32'(cpu_err), 32'd0);
        chk("reset cpu_busy", 32'(cpu_busy), 32'd0);
        chk("hburst", 32'(hburst), 32'd0);
        chk("hprot", 32'(hprot), 32'd3);
        chk("hmastlock", 32'(hmastlock), 32'd0);
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        @(posedge clk_in);
        #1;

        for (int i = 0; i < 13; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset during the data phase of a read must abandon it silently.
        cpu_en      = 1'b1;
        cpu_addr    = 32'h0000_0500;
        cpu_bytesel = 4'b0000;
        hready      = 1'b1;
        hresp       = 1'b0;
        @(posedge clk_in);
        #1;
        cpu_en = 1'b1;
        @(posedge clk_in);
        #1;
        hready = 1'b0;
        @(negedge clk_in);
        chk("abort in data phase busy", 32'(cpu_busy), 32'd1);
        rst = 1'b1;
        @(posedge clk_in);
        #1;
        rst    = 1'b0;
        cpu_en = 1'b0;
        hready = 1'b1;
        hrdata = 32'hFFFF_FFFF;
        @(negedge clk_in);
        chk("abort htrans", 32'(htrans), 32'd0);
        chk("abort cpu_busy", 32'(cpu_busy), 32'd0);
        chk("abort cpu_dout", cpu_dout, 32'd0);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            if (cpu_ready || cpu_err) pulses++;
            @(negedge clk_in);
        end
        chk("abort completion pulses", 32'(pulses), 32'd0);
        @(posedge clk_in);
        #1;
        model_dout = 32'h0;

        for (int n = 0; n < 60; n++) begin
            rv.addr = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 7))
                    0: rv.bs = 4'b0000;
                    1: rv.bs = 4'b1111;
                    2: rv.bs = 4'b0011;
                    3: rv.bs = 4'b1100;
                    4: rv.bs = 4'b0001;
                    5: rv.bs = 4'b0010;
                    6: rv.bs = 4'b0100;
                    default: rv.bs = 4'b1000;
                endcase
            end else begin
                rv.bs = 4'($urandom_range(0, 15));
            end
            rv.din  = $urandom;
            rv.aw   = $urandom_range(0, 2);
            rv.dw   = $urandom_range(0, 3);
            rv.er   = ($urandom_range(0, 3) == 0);
            rv.rd   = $urandom;
            rv.hold = ($urandom_range(0, 1) == 1);

            lg            = lanes_legal(rv.bs, sz, lo);
            rv.e_haddr    = {rv.addr[31:2], lo};
            rv.e_hsize    = sz;
            rv.e_hwrite   = (rv.bs != 4'b0000);
            rv.e_lat      = lg ? 3 + rv.aw + rv.dw + (rv.er ? 1 : 0) : 1;
            rv.e_err      = !lg || rv.er;
            if (lg && !rv.er && rv.bs == 4'b0000) model_dout = rv.rd;
            rv.e_dout     = model_dout;
            run_txn(rv, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nanorv32_ahb_master_bridge.md
NANORV32_AHB_MASTER_BRIDGE -- requirements
Module: nanorv32_ahb_master_bridge

Interface
REQ-001 clk_in  input  1  single clock for the whole block; all state changes on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk_in.
REQ-003 cpu_addr  input  32  request byte address.
REQ-004 cpu_bytesel  input  4  byte lanes; 4'b0000 = read, any other value = write.
REQ-005 cpu_din  input  32  write data, lane-aligned.
REQ-006 cpu_en  input  1  request strobe; sampled only in IDLE.
REQ-007 cpu_dout  output  32  read data, valid while cpu_ready=1.
REQ-008 cpu_ready  output  1  one-cycle completion pulse.
REQ-009 cpu_err  output  1  one-cycle error-completion pulse; mutually exclusive with cpu_ready.
REQ-010 cpu_busy  output  1  high whenever state != IDLE.
REQ-011 haddr  output  32, hwrite  output  1, hsize  output  3, hburst  output  3, hprot  output  4, htrans  output  2, hmastlock  output  1, hwdata  output  32  AHB-Lite master outputs.
REQ-012 hrdata  input  32, hready  input  1, hresp  input  1  AHB-Lite master inputs.

Function
REQ-013 The FSM SHALL have states IDLE, ADDR, DATA, ERR, DONE; all outputs SHALL be driven from registers.
REQ-014 Mapping from cpu_bytesel to hsize and haddr[1:0]: 1111 -> 010/00; 0011 -> 001/00; 1100 -> 001/10; 0001 -> 000/00; 0010 -> 000/01; 0100 -> 000/10; 1000 -> 000/11; 0000 (read) -> 010/00.
REQ-015 haddr[31:2] SHALL equal cpu_addr[31:2].
REQ-016 Any other nonzero bytesel is illegal: no AHB transfer SHALL be issued, and cpu_err SHALL pulse one cycle after cpu_en, with state IDLE -> DONE -> IDLE.
REQ-017 IDLE with cpu_en=1 and legal bytesel: capture address, size, hwrite (= bytesel!=0) and cpu_din, then go to ADDR; htrans SHALL be 2'b10 (NONSEQ) throughout ADDR.
REQ-018 ADDR: on hready=1, go to DATA with htrans=2'b00; on hready=0, hold all address-phase outputs unchanged.
REQ-019 DATA: hwdata SHALL hold the captured cpu_din.
  - hready=1, hresp=0: latch hrdata into cpu_dout (reads only; writes leave cpu_dout unchanged); go to DONE with cpu_ready=1.
  - hready=0, hresp=1: go to ERR.
  - hready=0, hresp=0: wait, unbounded.
REQ-020 ERR: on hready=1 (second cycle of the error response), go to DONE with cpu_err=1 and cpu_dout unchanged.
REQ-021 DONE lasts exactly one cycle and then returns to IDLE; cpu_en is ignored in DONE, so back-to-back requests are spaced by at least one IDLE cycle.
REQ-022 Zero-wait latency: cpu_en at edge N -> NONSEQ visible after edge N+1 -> cpu_ready high for the cycle after edge N+3.
REQ-023 hburst SHALL be constant 3'b000 (SINGLE); hprot constant 4'b0011; hmastlock constant 0.
REQ-024 htrans SHALL never be BUSY or SEQ.
REQ-025 cpu_en is ignored in any state other than IDLE; no request is queued.

Reset
REQ-026 While rst=1 at a clock edge:
  - state = IDLE; htrans = 00; haddr = 0; hwrite = 0; hsize = 010; hwdata = 0.
  - cpu_dout = 0; cpu_ready = 0; cpu_err = 0; cpu_busy = 0.
REQ-027 rst asserted mid-transfer (any state) SHALL abandon the transfer without a cpu_ready or cpu_err pulse; htrans SHALL be 00 on the following cycle.

Verification
REQ-028 Word write, zero-wait: addr=0x4000_0008, bytesel=1111, din=0xDEADBEEF -> one NONSEQ, haddr=0x4000_0008, hsize=010, hwrite=1; hwdata=0xDEADBEEF in the data phase; cpu_ready pulses 3 cycles after cpu_en.
REQ-029 Byte read with 2 data-phase wait states: addr=0x4000_0003, bytesel=0000 -> hsize=010, haddr=0x4000_0000; slave returns hrdata=0x11223344 -> cpu_dout=0x11223344 and cpu_ready pulses 5 cycles after cpu_en.
REQ-030 Halfword write, bytesel=1100, addr=0x100 -> haddr=0x102, hsize=001.
REQ-031 Illegal bytesel=0101 -> htrans stays 00; cpu_err pulses once.
REQ-032 Error response: slave drives hready=0/hresp=1, then hready=1/hresp=1 -> cpu_err pulses once; cpu_ready stays 0; cpu_dout is unchanged.
REQ-033 cpu_en held high through a transfer -> exactly one AHB transfer per accepted request; rst pulsed during DATA -> no completion pulse, htrans=00, cpu_busy=0.
